// File: rtl/async_fifo_gray.sv
// rtl/async_fifo_gray.sv - dual-clock FIFO with Gray-coded pointer crossings
module async_fifo_gray #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int AF_THRESH   = 12,
    parameter int AE_THRESH   = 4
) (
    input  logic                  wr_clk,
    input  logic                  rd_clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   wr_level,
    output logic                  overflow,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   rd_level,
    output logic                  underflow
);
    localparam int AW    = ADDR_WIDTH;
    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] AF_T = (AW+1)'(AF_THRESH);
    localparam logic [AW:0] AE_T = (AW+1)'(AE_THRESH);

    function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
        logic [AW:0] b;
        b = g;
        for (int i = 1; i <= AW; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [1:0]  wr_rst_pipe;
    logic [1:0]  rd_rst_pipe;
    logic        wr_rstn;
    logic        rd_rstn;

    logic [AW:0] wbin, wgray, wbin_next, wgray_next;
    logic [AW:0] rbin, rgray, rbin_next, rgray_next;
    logic [AW:0] rq_sync [SYNC_STAGES];
    logic [AW:0] wq_sync [SYNC_STAGES];
    logic [AW:0] rq_s, wq_s;
    logic        wr_inc, rd_inc;

    assign wr_rstn    = wr_rst_pipe[1];
    assign rd_rstn    = rd_rst_pipe[1];
    assign rq_s       = rq_sync[SYNC_STAGES-1];
    assign wq_s       = wq_sync[SYNC_STAGES-1];
    assign wr_inc     = wr_en && !full;
    assign rd_inc     = rd_en && !empty;
    assign wbin_next  = wbin + {{AW{1'b0}}, wr_inc};
    assign rbin_next  = rbin + {{AW{1'b0}}, rd_inc};
    assign wgray_next = bin2gray(wbin_next);
    assign rgray_next = bin2gray(rbin_next);

    // Write-domain reset: immediate assertion, release aligned to wr_clk
    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) wr_rst_pipe <= 2'b00;
        else        wr_rst_pipe <= {wr_rst_pipe[0], 1'b1};
    end

    // Read-domain reset: immediate assertion, release aligned to rd_clk
    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) rd_rst_pipe <= 2'b00;
        else        rd_rst_pipe <= {rd_rst_pipe[0], 1'b1};
    end

    // Bring the read Gray pointer into the write domain
    always_ff @(posedge wr_clk or negedge wr_rstn) begin
        if (!wr_rstn) begin
            for (int i = 0; i < SYNC_STAGES; i++) rq_sync[i] <= '0;
        end else begin
            rq_sync[0] <= rgray;
            for (int i = 1; i < SYNC_STAGES; i++) rq_sync[i] <= rq_sync[i-1];
        end
    end

    // Bring the write Gray pointer into the read domain
    always_ff @(posedge rd_clk or negedge rd_rstn) begin
        if (!rd_rstn) begin
            for (int i = 0; i < SYNC_STAGES; i++) wq_sync[i] <= '0;
        end else begin
            wq_sync[0] <= wgray;
            for (int i = 1; i < SYNC_STAGES; i++) wq_sync[i] <= wq_sync[i-1];
        end
    end

    // Storage write; contents need no reset since pointers gate visibility
    always_ff @(posedge wr_clk) begin
        if (wr_inc) mem[wbin[AW-1:0]] <= wr_data;
    end

    // Write pointer, full flag, level and overflow bookkeeping
    always_ff @(posedge wr_clk or negedge wr_rstn) begin
        if (!wr_rstn) begin
            wbin        <= '0;
            wgray       <= '0;
            full        <= 1'b0;
            wr_level    <= '0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            wbin        <= wbin_next;
            wgray       <= wgray_next;
            full        <= (wgray_next == {~rq_s[AW:AW-1], rq_s[AW-2:0]});
            wr_level    <= wbin_next - gray2bin(rq_s);
            almost_full <= (wr_level >= AF_T);
            overflow    <= overflow | (wr_en && full);
        end
    end

    // Read pointer, data/strobe, empty flag, level and underflow bookkeeping
    always_ff @(posedge rd_clk or negedge rd_rstn) begin
        if (!rd_rstn) begin
            rbin         <= '0;
            rgray        <= '0;
            rd_data      <= '0;
            rd_valid     <= 1'b0;
            empty        <= 1'b1;
            rd_level     <= '0;
            almost_empty <= 1'b1;
            underflow    <= 1'b0;
        end else begin
            rbin         <= rbin_next;
            rgray        <= rgray_next;
            rd_valid     <= rd_inc;
            if (rd_inc) rd_data <= mem[rbin[AW-1:0]];
            empty        <= (rgray_next == wq_s);
            rd_level     <= gray2bin(wq_s) - rbin_next;
            almost_empty <= (rd_level <= AE_T);
            underflow    <= underflow | (rd_en && empty);
        end
    end
endmodule

// File: tb/tb_async_fifo_gray.sv
// tb/tb_async_fifo_gray.sv - randomized scoreboard bench for async_fifo_gray
`timescale 1ns/1ps
module tb_async_fifo_gray;
    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          wr_clk = 1'b0;
    logic          rd_clk = 1'b0;
    logic          rst_n  = 1'b0;
    logic          wr_en  = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_en  = 1'b0;
    logic          full, almost_full, overflow;
    logic          rd_valid, empty, almost_empty, underflow;
    logic [AW:0]   wr_level, rd_level;
    logic [DW-1:0] rd_data;

    real wr_half = 5.0;
    real rd_half = 13.5;

    always #(wr_half) wr_clk = ~wr_clk;
    always #(rd_half) rd_clk = ~rd_clk;

    async_fifo_gray dut (
        .wr_clk(wr_clk), .rd_clk(rd_clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_data(wr_data), .full(full),
        .almost_full(almost_full), .wr_level(wr_level), .overflow(overflow),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty),
        .almost_empty(almost_empty), .rd_level(rd_level), .underflow(underflow)
    );

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] sb_q[$];
    int            occ = 0;
    int            rd_acc_cnt = 0;
    int            mon_cnt = 0;
    int            wr_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge rd_clk) begin
        #1;
        if (rd_valid === 1'b1) begin
            mon_cnt++;
            if (sb_q.size() == 0) chk("rd_unexpected", 1, 0);
            else chk("rd_data_order", rd_data, sb_q.pop_front());
        end
    end

    task automatic write_cycle(input bit en, input logic [DW-1:0] d, output bit acc);
        @(negedge wr_clk);
        wr_en = en;
        wr_data = d;
        acc = en && (full === 1'b0);
        if (acc) chk("no_write_past_depth", occ < DEPTH, 1);
        @(posedge wr_clk);
        if (acc) begin
            sb_q.push_back(d);
            occ++;
        end
        #0.5 wr_en = 1'b0;
    endtask

    task automatic read_cycle(input bit en, output bit acc);
        @(negedge rd_clk);
        rd_en = en;
        acc = en && (empty === 1'b0);
        if (acc) chk("no_read_of_nothing", occ > 0, 1);
        @(posedge rd_clk);
        if (acc) begin
            occ--;
            rd_acc_cnt++;
        end
        #0.5 rd_en = 1'b0;
    endtask

    task automatic wr_idle(input int n);
        repeat (n) @(negedge wr_clk);
    endtask

    task automatic rd_idle(input int n);
        repeat (n) @(negedge rd_clk);
    endtask

    task automatic fill(input int n, input bit counting, input logic [DW-1:0] base);
        int got = 0;
        int c = 0;
        bit acc;
        while (got < n && c < 400) begin
            write_cycle(1'b1, counting ? base + DW'(got) : DW'($urandom), acc);
            if (acc) got++;
            c++;
        end
        chk("fill_count", got, n);
    endtask

    task automatic rd_n(input int n);
        int got = 0;
        int c = 0;
        bit acc;
        while (got < n && c < 400) begin
            read_cycle(1'b1, acc);
            if (acc) got++;
            c++;
        end
        chk("read_count", got, n);
    endtask

    task automatic drain();
        int c = 0;
        bit acc;
        while (occ > 0 && c < 400) begin
            read_cycle(1'b1, acc);
            c++;
        end
        chk("drain_done", occ, 0);
        rd_idle(3);
        chk("scoreboard_empty", sb_q.size(), 0);
        chk("valid_matches_reads", mon_cnt, rd_acc_cnt);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        sb_q.delete();
        occ = 0;
        repeat (3) @(negedge wr_clk);
        rst_n = 1'b1;
        wr_idle(5);
        rd_idle(5);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_empty"}, empty, 1);
        chk({tag, "_almost_empty"}, almost_empty, 1);
        chk({tag, "_full"}, full, 0);
        chk({tag, "_almost_full"}, almost_full, 0);
        chk({tag, "_wr_level"}, wr_level, 0);
        chk({tag, "_rd_level"}, rd_level, 0);
        chk({tag, "_overflow"}, overflow, 0);
        chk({tag, "_underflow"}, underflow, 0);
        chk({tag, "_rd_valid"}, rd_valid, 0);
    endtask

    task automatic phase(input real wh, input real rh, input int n);
        wr_half = wh;
        rd_half = rh;
        wr_idle(2);
        fork
            begin
                int got = 0;
                int c = 0;
                bit acc;
                while (got < n && c < 20000) begin
                    write_cycle($urandom_range(0, 3) != 0, DW'($urandom), acc);
                    if (acc) got++;
                    c++;
                end
                chk("phase_writes", got, n);
                wr_total += got;
            end
            begin
                int target = rd_acc_cnt + n;
                int c = 0;
                bit acc;
                while (rd_acc_cnt < target && c < 20000) begin
                    read_cycle($urandom_range(0, 3) != 0, acc);
                    c++;
                end
                chk("phase_reads", rd_acc_cnt, target);
            end
        join
        rd_idle(3);
        chk("phase_scoreboard_empty", sb_q.size(), 0);
        chk("phase_valid_matches_reads", mon_cnt, rd_acc_cnt);
        chk("phase_empty_at_end", empty, 1);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        do_reset();
        check_idle("reset");
        chk("reset_rd_data", rd_data, 0);

        // read while empty
        read_cycle(1'b1, acc);
        chk("empty_read_accepted", acc, 0);
        rd_idle(2);
        chk("empty_read_underflow", underflow, 1);
        chk("empty_read_rd_valid", rd_valid, 0);
        chk("empty_read_rd_data", rd_data, 0);
        chk("empty_read_no_strobe", mon_cnt, 0);
        do_reset();
        check_idle("reset2");

        // fill to depth, overflow attempt, drain
        fill(16, 1'b1, 8'h00);
        @(negedge wr_clk);
        chk("full_after_16", full, 1);
        chk("wr_level_16", wr_level, 16);
        write_cycle(1'b1, 8'hAA, acc);
        chk("wr17_dropped", acc, 0);
        @(negedge wr_clk);
        chk("overflow_set", overflow, 1);
        rd_idle(6);
        chk("rd_level_16", rd_level, 16);
        chk("almost_empty_at_16", almost_empty, 0);
        drain();
        chk("drained_empty", empty, 1);
        chk("drained_underflow", underflow, 0);
        chk("drained_rd_level", rd_level, 0);
        wr_idle(8);
        chk("overflow_sticky", overflow, 1);
        chk("drained_wr_level", wr_level, 0);
        chk("drained_full", full, 0);

        // almost-full / almost-empty thresholds
        fill(11, 1'b0, 8'h00);
        wr_idle(2);
        chk("wr_level_11", wr_level, 11);
        chk("almost_full_at_11", almost_full, 0);
        fill(1, 1'b0, 8'h00);
        wr_idle(2);
        chk("wr_level_12", wr_level, 12);
        chk("almost_full_at_12", almost_full, 1);
        rd_idle(6);
        chk("rd_level_12", rd_level, 12);
        chk("almost_empty_at_12", almost_empty, 0);
        rd_n(7);
        rd_idle(2);
        chk("rd_level_5", rd_level, 5);
        chk("almost_empty_at_5", almost_empty, 0);
        rd_n(1);
        rd_idle(2);
        chk("rd_level_4", rd_level, 4);
        chk("almost_empty_at_4", almost_empty, 1);
        wr_idle(8);
        chk("wr_level_4", wr_level, 4);
        chk("almost_full_at_4", almost_full, 0);
        drain();

        // continuous random traffic at 3:1 and 1:3 clock ratios
        phase(5.0, 15.0, 500);
        phase(15.0, 5.0, 500);
        chk("ptr_wraps_ge_60", (wr_total / DEPTH) >= 60, 1);

        // reset while half full with a write in flight
        wr_half = 5.0;
        rd_half = 13.5;
        wr_idle(2);
        fill(8, 1'b0, 8'h00);
        @(negedge wr_clk);
        wr_en = 1'b1;
        wr_data = 8'h77;
        #2 rst_n = 1'b0;
        do_reset();
        check_idle("midreset");
        write_cycle(1'b1, 8'h55, acc);
        chk("post_reset_wr0", acc, 1);
        write_cycle(1'b1, 8'h66, acc);
        chk("post_reset_wr1", acc, 1);
        rd_idle(6);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
